// File: rtl/hist_remap_output.sv
// hist_remap_output
//   Output side of the histogram-equalization ping-pong handshake. On a
//   rising output_start it walks every pixel of the selected bank. For each
//   pixel it reads the pixel value, looks up its CDF entry, and computes
//   ((cdf - cdf_min) * 255) / divisor with an 8-step restoring divider. It
//   streams each result out over valid/ready and pulses output_done at the
//   end of the frame.
//
// Ports
//   clock, reset          : system clock, asynchronous active-high reset
//   output_start          : level request, held until output_done is seen
//   output_base_offset    : bank select, sampled at start
//   Cdf_Min_Out, Divisor  : frame constants, sampled at start
//   output_done           : one-cycle frame-complete pulse
//   pix_rd/pix_addr       : pixel read strobe and {bank,index}; pix_data returns next cycle
//   cdf_rd/cdf_addr       : CDF read strobe and address; cdf_data returns next cycle
//   out_valid/out_ready   : result handshake
//   out_pixel/out_addr    : equalized value and its {bank,index}
module hist_remap_output #(
    parameter int unsigned NUM_PIXELS = 307200,
    parameter int unsigned IDX_W      = 19,
    parameter int unsigned CDF_W      = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             output_start,
    input  logic             output_base_offset,
    input  logic [CDF_W-1:0] Cdf_Min_Out,
    input  logic [CDF_W-1:0] Divisor,
    output logic             output_done,
    output logic             pix_rd,
    output logic [IDX_W:0]   pix_addr,
    input  logic [7:0]       pix_data,
    output logic             cdf_rd,
    output logic [7:0]       cdf_addr,
    input  logic [CDF_W-1:0] cdf_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_pixel,
    output logic [IDX_W:0]   out_addr
);

    localparam int unsigned      NUM_W    = CDF_W + 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PIX_REQ, S_CDF_REQ, S_CALC, S_DIV, S_OUT, S_DONE, S_REARM
    } state_t;

    state_t             state_q, state_d;
    logic               bank_q, bank_d;
    logic [CDF_W-1:0]   cmin_q, cmin_d;
    logic [CDF_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_W-1:0]   rem_q, rem_d;
    logic [NUM_W-1:0]   dsh_q, dsh_d;
    logic [7:0]         quot_q, quot_d;
    logic [2:0]         step_q, step_d;

    logic [CDF_W-1:0]   diff;
    logic [NUM_W-1:0]   num;

    // CDF entries at or below cdf_min clamp to zero instead of underflowing.
    assign diff = (cdf_data > cmin_q) ? (cdf_data - cmin_q) : '0;
    // diff * 255 as a shift and a subtract.
    assign num  = {diff, 8'h00} - {8'h00, diff};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bank_q  <= 1'b0;
            cmin_q  <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            dsh_q   <= '0;
            quot_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            cmin_q  <= cmin_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            dsh_q   <= dsh_d;
            quot_q  <= quot_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        cmin_d      = cmin_q;
        div_d       = div_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        dsh_d       = dsh_q;
        quot_d      = quot_q;
        step_d      = step_q;
        output_done = 1'b0;
        pix_rd      = 1'b0;
        cdf_rd      = 1'b0;
        cdf_addr    = '0;
        out_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (output_start) begin
                    bank_d  = output_base_offset;
                    cmin_d  = Cdf_Min_Out;
                    div_d   = Divisor;
                    idx_d   = '0;
                    state_d = S_PIX_REQ;
                end
            end
            S_PIX_REQ: begin
                pix_rd  = 1'b1;
                state_d = S_CDF_REQ;
            end
            S_CDF_REQ: begin
                cdf_rd   = 1'b1;
                cdf_addr = pix_data;
                state_d  = S_CALC;
            end
            S_CALC: begin
                rem_d  = num;
                // The divisor starts aligned with quotient bit 7 and shifts right
                // one place per step.
                dsh_d  = {1'b0, div_q, 7'b0};
                step_d = '0;
                quot_d = '0;
                if (div_q == '0) begin
                    quot_d  = (diff != '0) ? 8'hFF : 8'h00;
                    state_d = S_OUT;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (rem_q >= dsh_q) begin
                    rem_d  = rem_q - dsh_q;
                    quot_d = {quot_q[6:0], 1'b1};
                end else begin
                    quot_d = {quot_q[6:0], 1'b0};
                end
                dsh_d  = dsh_q >> 1;
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_PIX_REQ;
                    end
                end
            end
            S_DONE: begin
                output_done = 1'b1;
                state_d     = S_REARM;
            end
            S_REARM: begin
                // The request must drop before another frame may start.
                if (!output_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pix_addr  = {bank_q, idx_q};
    assign out_addr  = {bank_q, idx_q};
    assign out_pixel = quot_q;

endmodule
